// File: rtl/div_pkg.sv
// div_pkg: shared state/status encodings and size helpers for fxp_seq_divider.
// The SIGN state is only reachable when DIV_SIGNED_EN is defined.
package div_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_SIGN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_LOAD = S_LOAD,
    ST_RUN  = S_RUN,
    ST_SIGN = S_SIGN,
    ST_DONE = S_DONE
  } div_state_e;

  typedef enum logic [1:0] {
    STAT_NONE  = 2'd0,
    STAT_VALID = 2'd1,
    STAT_DVZ   = 2'd2,
    STAT_OVF   = 2'd3
  } div_status_e;

  function automatic int unsigned div_n(input int unsigned width, input int unsigned frac);
    return width + frac;
  endfunction

  function automatic int unsigned div_cw(input int unsigned width, input int unsigned frac);
    return $clog2(width + frac + 1);
  endfunction

endpackage

// File: rtl/div_datapath.sv
// div_datapath: ACC/Q/B/counter registers, restoring step subtractor and result shaping.
// Magnitude conversion and sign fix-up exist only when DIV_SIGNED_EN is defined.
module div_datapath
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_capture,
  input  logic             i_init,
  input  logic             i_step,
  input  logic             i_sgn,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_dz,
  output logic             o_early,
  output logic             o_last,
  output logic             o_res_ovf,
  output logic [WIDTH-1:0] o_q_res,
  output logic [WIDTH-1:0] o_r_res
);

  localparam int unsigned N  = div_n(WIDTH, FRAC);
  localparam int unsigned CW = div_cw(WIDTH, FRAC);

  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_b;
  logic [N-1:0]     r_q;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_shacc;
  logic [WIDTH:0]   w_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_dd_mag;
  logic [WIDTH-1:0] w_ds_mag;

  // ACC stays below B, so only the shifted value needs the extra bit
  assign w_shacc   = {r_acc, r_q[N-1]};
  assign w_ge      = (w_shacc >= {1'b0, r_b});
  assign w_sub     = w_shacc - {1'b0, r_b};
  assign w_acc_nxt = WIDTH'(w_ge ? w_sub : w_shacc);

  assign o_dz    = (r_divisor == '0);
  assign o_early = w_ge && (r_cnt < CW'(FRAC));
  assign o_last  = (r_cnt == CW'(N - 1));

`ifdef DIV_SIGNED_EN
  logic             r_sgn;
  logic             w_dd_neg;
  logic             w_ds_neg;
  logic             w_neg_q;
  logic [WIDTH-1:0] w_qm;

  assign w_dd_neg = r_sgn & r_dividend[WIDTH-1];
  assign w_ds_neg = r_sgn & r_divisor[WIDTH-1];
  assign w_dd_mag = w_dd_neg ? (~r_dividend + WIDTH'(1)) : r_dividend;
  assign w_ds_mag = w_ds_neg ? (~r_divisor + WIDTH'(1)) : r_divisor;

  // Sign fix-up works on the settled registers during the SIGN state
  assign w_qm      = r_q[WIDTH-1:0];
  assign w_neg_q   = w_dd_neg ^ w_ds_neg;
  assign o_q_res   = w_neg_q ? (~w_qm + WIDTH'(1)) : w_qm;
  assign o_r_res   = w_dd_neg ? (~r_acc + WIDTH'(1)) : r_acc;
  assign o_res_ovf = w_neg_q ? (w_qm[WIDTH-1] && (|w_qm[WIDTH-2:0]))
                             : (r_sgn && w_qm[WIDTH-1]);
`else
  logic w_unused_sgn;

  assign w_unused_sgn = i_sgn;
  assign w_dd_mag     = r_dividend;
  assign w_ds_mag     = r_divisor;

  // Unsigned results come straight from the final step's next-state values
  assign o_q_res   = WIDTH'({r_q[N-2:0], w_ge});
  assign o_r_res   = w_acc_nxt;
  assign o_res_ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_acc      <= '0;
      r_b        <= '0;
      r_q        <= '0;
      r_cnt      <= '0;
`ifdef DIV_SIGNED_EN
      r_sgn      <= 1'b0;
`endif
    end else begin
      if (i_capture) begin
        r_dividend <= i_dividend;
        r_divisor  <= i_divisor;
`ifdef DIV_SIGNED_EN
        r_sgn      <= i_sgn;
`endif
      end
      if (i_init) begin
        r_acc <= '0;
        r_q   <= N'(w_dd_mag) << FRAC;
        r_b   <= w_ds_mag;
        r_cnt <= '0;
      end else if (i_step) begin
        r_acc <= w_acc_nxt;
        r_q   <= {r_q[N-2:0], w_ge};
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fxp_seq_divider.sv
// fxp_seq_divider: multi-cycle restoring divider computing (dividend<<FRAC)/divisor.
// Define DIV_SIGNED_EN to honour sgn and add the SIGN fix-up state.
module fxp_seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic             dvz,
  output logic             ovf,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_e       r_state;
  div_state_e       w_next;
  div_status_e      w_stat;
  logic             w_capture;
  logic             w_init;
  logic             w_step;
  logic             w_dz;
  logic             w_early;
  logic             w_last;
  logic             w_res_ovf;
  logic [WIDTH-1:0] w_q_res;
  logic [WIDTH-1:0] w_r_res;

  logic             r_valid;
  logic             r_dvz;
  logic             r_ovf;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;

  div_datapath #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_datapath (
    .clk        (clk),
    .i_rst_n    (rst),
    .i_capture  (w_capture),
    .i_init     (w_init),
    .i_step     (w_step),
    .i_sgn      (sgn),
    .i_dividend (dividend),
    .i_divisor  (divisor),
    .o_dz       (w_dz),
    .o_early    (w_early),
    .o_last     (w_last),
    .o_res_ovf  (w_res_ovf),
    .o_q_res    (w_q_res),
    .o_r_res    (w_r_res)
  );

  // Status is decided on the edge entering DONE so the pulse and result share that cycle
  always_comb begin
    w_next    = r_state;
    w_stat    = STAT_NONE;
    w_capture = 1'b0;
    w_init    = 1'b0;
    w_step    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_capture = 1'b1;
          w_next    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_dz) begin
          w_stat = STAT_DVZ;
          w_next = ST_DONE;
        end else begin
          w_init = 1'b1;
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (w_early) begin
          w_stat = STAT_OVF;
          w_next = ST_DONE;
        end else if (w_last) begin
`ifdef DIV_SIGNED_EN
          w_next = ST_SIGN;
`else
          w_stat = w_res_ovf ? STAT_OVF : STAT_VALID;
          w_next = ST_DONE;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      ST_SIGN: begin
        w_stat = w_res_ovf ? STAT_OVF : STAT_VALID;
        w_next = ST_DONE;
      end
`endif
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_dvz   <= 1'b0;
      r_ovf   <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= (w_stat == STAT_VALID);
      r_dvz   <= (w_stat == STAT_DVZ);
      r_ovf   <= (w_stat == STAT_OVF);
      if (w_stat == STAT_VALID) begin
        r_quot <= w_q_res;
        r_rem  <= w_r_res;
      end else if (w_stat != STAT_NONE) begin
        r_quot <= '0;
        r_rem  <= '0;
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign valid     = r_valid;
  assign dvz       = r_dvz;
  assign ovf       = r_ovf;
  assign quotient  = r_quot;
  assign remainder = r_rem;

endmodule

// File: tb/tb_fxp_seq_divider.sv
// tb_fxp_seq_divider: directed vector table plus hand sequences for fxp_seq_divider (WIDTH=8, FRAC=4).
// Expectations for signed vectors follow DIV_SIGNED_EN when it is defined.
module tb_fxp_seq_divider;

  localparam int K_VAL = 0;
  localparam int K_DVZ = 1;
  localparam int K_OVF = 2;
`ifdef DIV_SIGNED_EN
  localparam int LAT = 15;
`else
  localparam int LAT = 14;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    int         kind;
    logic [7:0] q;
    logic [7:0] r;
    int         cyc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sgn = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, valid, dvz, ovf;
  logic [7:0] quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  fxp_seq_divider #(
    .WIDTH (8),
    .FRAC  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sgn       (sgn),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .valid     (valid),
    .dvz       (dvz),
    .ovf       (ovf),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Assumes the caller is in cycle 1; returns the cycle of the first pulse or -1
  task automatic wait_pulse(input int inj, output int cyc);
    cyc = 1;
    while (!(valid || dvz || ovf) && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (inj != 0) begin
        start = (cyc == inj);
        if (cyc == inj) begin
          dividend = 8'd200;
          divisor  = 8'd1;
          sgn      = 1'b0;
        end
      end
    end
    if (!(valid || dvz || ovf)) cyc = -1;
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input int inj, output int cyc);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sgn      = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_pulse(inj, cyc);
  endtask

  task automatic check_res(input string tag, input int cyc, input int kind, input int ecyc,
                           input logic [7:0] eq, input logic [7:0] er);
    chk({tag, ".cycle"}, 32'(cyc), 32'(ecyc));
    chk({tag, ".valid"}, 32'(valid), 32'(kind == K_VAL));
    chk({tag, ".dvz"}, 32'(dvz), 32'(kind == K_DVZ));
    chk({tag, ".ovf"}, 32'(ovf), 32'(kind == K_OVF));
    chk({tag, ".quotient"}, 32'(quotient), 32'(eq));
    chk({tag, ".remainder"}, 32'(remainder), 32'(er));
    @(posedge clk);
    #1;
    chk({tag, ".pulse_end"}, 32'({valid, dvz, ovf}), 32'(0));
    chk({tag, ".busy_low"}, 32'(busy), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int pulses;

    vecs.push_back('{8'h06, 8'h04, 1'b0, K_VAL, 8'h18, 8'h00, LAT});
    vecs.push_back('{8'h07, 8'h03, 1'b0, K_VAL, 8'h25, 8'h01, LAT});
    vecs.push_back('{8'h05, 8'h00, 1'b0, K_DVZ, 8'h00, 8'h00, 2});
    vecs.push_back('{8'hC8, 8'h01, 1'b0, K_OVF, 8'h00, 8'h00, 3});
    vecs.push_back('{8'h0F, 8'h04, 1'b0, K_VAL, 8'h3C, 8'h00, LAT});
    vecs.push_back('{8'h01, 8'h03, 1'b0, K_VAL, 8'h05, 8'h01, LAT});
    vecs.push_back('{8'h00, 8'h05, 1'b0, K_VAL, 8'h00, 8'h00, LAT});
    vecs.push_back('{8'h0F, 8'h01, 1'b0, K_VAL, 8'hF0, 8'h00, LAT});
    vecs.push_back('{8'h10, 8'h01, 1'b0, K_OVF, 8'h00, 8'h00, 6});
    vecs.push_back('{8'hFF, 8'h10, 1'b0, K_VAL, 8'hFF, 8'h00, LAT});
    vecs.push_back('{8'h64, 8'h07, 1'b0, K_VAL, 8'hE4, 8'h04, LAT});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, K_VAL, 8'h10, 8'h00, LAT});
    vecs.push_back('{8'h7F, 8'h01, 1'b1, K_OVF, 8'h00, 8'h00, 4});
    vecs.push_back('{8'h00, 8'h00, 1'b1, K_DVZ, 8'h00, 8'h00, 2});
`ifdef DIV_SIGNED_EN
    vecs.push_back('{8'hFA, 8'h04, 1'b1, K_VAL, 8'hE8, 8'h00, LAT});
    vecs.push_back('{8'h06, 8'hFC, 1'b1, K_VAL, 8'hE8, 8'h00, LAT});
    vecs.push_back('{8'hFA, 8'hFC, 1'b1, K_VAL, 8'h18, 8'h00, LAT});
    vecs.push_back('{8'hF9, 8'h03, 1'b1, K_VAL, 8'hDB, 8'hFF, LAT});
    vecs.push_back('{8'h08, 8'h01, 1'b1, K_OVF, 8'h00, 8'h00, LAT});
    vecs.push_back('{8'hF8, 8'h01, 1'b1, K_VAL, 8'h80, 8'h00, LAT});
`else
    vecs.push_back('{8'hFA, 8'h04, 1'b1, K_OVF, 8'h00, 8'h00, 5});
    vecs.push_back('{8'hF9, 8'h03, 1'b1, K_OVF, 8'h00, 8'h00, 4});
`endif

    // Reset state
    #1 rst = 1'b0;
    #2;
    chk("reset.busy", 32'(busy), 32'(0));
    chk("reset.valid", 32'(valid), 32'(0));
    chk("reset.dvz", 32'(dvz), 32'(0));
    chk("reset.ovf", 32'(ovf), 32'(0));
    chk("reset.quotient", 32'(quotient), 32'(0));
    chk("reset.remainder", 32'(remainder), 32'(0));
    #19 rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].s, 0, cyc);
      check_res($sformatf("v%0d", i), cyc, vecs[i].kind, vecs[i].cyc, vecs[i].q, vecs[i].r);
    end

    // Start pulsed mid-run is ignored and must not restart afterwards
    do_op(8'h07, 8'h03, 1'b0, 5, cyc);
    check_res("midstart", cyc, K_VAL, LAT, 8'h25, 8'h01);
    @(posedge clk);
    #1;
    chk("midstart.no_restart", 32'(busy), 32'(0));

    // Start held from the DONE cycle is taken only once back in IDLE
    do_op(8'h06, 8'h04, 1'b0, 0, cyc);
    chk("done_start.first_valid", 32'(valid), 32'(1));
    start    = 1'b1;
    dividend = 8'h01;
    divisor  = 8'h03;
    sgn      = 1'b0;
    @(posedge clk);
    #1;
    chk("done_start.idle", 32'(busy), 32'(0));
    @(posedge clk);
    #1;
    chk("done_start.accept", 32'(busy), 32'(1));
    start = 1'b0;
    wait_pulse(0, cyc);
    check_res("done_start", cyc, K_VAL, LAT, 8'h05, 8'h01);

    // Asynchronous reset during RUN clears everything and produces no pulse
    start    = 1'b1;
    dividend = 8'h07;
    divisor  = 8'h03;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("rst_run.busy_before", 32'(busy), 32'(1));
    rst = 1'b0;
    #1;
    chk("rst_run.busy", 32'(busy), 32'(0));
    chk("rst_run.quotient", 32'(quotient), 32'(0));
    chk("rst_run.remainder", 32'(remainder), 32'(0));
    chk("rst_run.flags", 32'({valid, dvz, ovf}), 32'(0));
    #2 rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (valid || dvz || ovf || busy) pulses++;
    end
    chk("rst_run.silent", 32'(pulses), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
